// File: rtl/iter_div_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iter_div_16_pkg
// Brief    : Shared widths, state encoding and constants for iter_div_16.
// Revision : 1.0
// ============================================================================
package iter_div_16_pkg;

    localparam int DIV_W = 16;
    localparam int SUB_W = 20;

    localparam logic [DIV_W-1:0] DIV0_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/iter_div_16_if.sv
`default_nettype none
// ============================================================================
// Module   : iter_div_16_if
// Brief    : Operand and result handshakes for the iterative divider.
// Revision : 1.0
// ============================================================================
interface iter_div_16_if;
    import iter_div_16_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/iter_div_16_mcls_20_sub.sv
`default_nettype none
// ============================================================================
// Module   : mcls_20_sub
// Brief    : 20-bit a - b as a + ~b + 1 over five 4-bit carry-lookahead groups.
// Revision : 1.0
// ============================================================================
module mcls_20_sub
    import iter_div_16_pkg::*;
(
    input  wire logic [SUB_W-1:0] a_i,
    input  wire logic [SUB_W-1:0] b_i,
    output logic      [SUB_W-1:0] diff_o
);
    localparam int NGRP = SUB_W / 4;

    logic [SUB_W-1:0] w_g;
    logic [SUB_W-1:0] w_p;
    logic [SUB_W-1:0] w_c;
    logic [NGRP-1:0]  w_gg;
    logic [NGRP-1:0]  w_gp;
    logic [NGRP:0]    w_cg;

    assign w_g   = a_i & ~b_i;
    assign w_p   = a_i ^ ~b_i;
    assign w_cg[0] = 1'b1;

    generate
        for (genvar k = 0; k < NGRP; k++) begin : g_grp
            localparam int B = 4 * k;
            assign w_c[B]   = w_cg[k];
            assign w_c[B+1] = w_g[B] | (w_p[B] & w_cg[k]);
            assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_cg[k]);
            assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_cg[k]);
            assign w_gg[k]  = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                            | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
            assign w_gp[k]  = &w_p[B+3:B];
            assign w_cg[k+1] = w_gg[k] | (w_gp[k] & w_cg[k]);
        end
    endgenerate

    assign diff_o = w_p ^ w_c;

    // Final carry-out is implied by diff[19] for zero-padded operands.
    logic w_unused_cout;
    assign w_unused_cout = w_cg[NGRP];

endmodule
`default_nettype wire

// File: rtl/iter_div_16.sv
`default_nettype none
// ============================================================================
// Module   : iter_div_16
// Brief    : Unsigned 16/16 radix-2 restoring divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module iter_div_16
    import iter_div_16_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    iter_div_16_if.slave bus
);
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   quot_q,  quot_d;
    logic [DIV_W-1:0]   dvsr_q,  dvsr_d;
    logic [DIV_W:0]     rem_q,   rem_d;
    logic [3:0]         cnt_q,   cnt_d;
    logic               dz_q,    dz_d;

    logic [DIV_W:0]     w_trial;
    logic [SUB_W-1:0]   w_diff;
    logic               w_borrow;

    assign w_trial = {rem_q[DIV_W-1:0], quot_q[DIV_W-1]};

    mcls_20_sub u_sub (
        .a_i    ({3'b000, w_trial}),
        .b_i    ({4'b0000, dvsr_q}),
        .diff_o (w_diff)
    );

    assign w_borrow = w_diff[SUB_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvsr_d = bus.divisor;
                    cnt_d  = '0;
                    if (bus.divisor == '0) begin
                        quot_d  = DIV0_QUOT;
                        rem_d   = {1'b0, bus.dividend};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        quot_d  = bus.dividend;
                        rem_d   = '0;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Restore by keeping the trial value when the subtraction borrows.
                if (!w_borrow) begin
                    rem_d  = w_diff[DIV_W:0];
                    quot_d = {quot_q[DIV_W-2:0], 1'b1};
                end else begin
                    rem_d  = w_trial;
                    quot_d = {quot_q[DIV_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q[DIV_W-1:0];
    assign bus.div_zero  = dz_q;

    logic w_unused;
    assign w_unused = ^{rem_q[DIV_W], w_diff[SUB_W-2:DIV_W+1]};

endmodule
`default_nettype wire

// File: tb/tb_iter_div_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_div_16
// Brief    : Directed and random checks of iter_div_16 against an arithmetic model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_iter_div_16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iter_div_16_if bus();

    iter_div_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: plain integer division, with the all-ones / dividend convention for b==0.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL model_empty actual=out_valid required=no_result");
            end else begin
                op_t         op;
                logic [15:0] eq, er;
                logic        ez;
                op = exp_q[0];
                ez = (op.b == 16'd0);
                eq = ez ? 16'hFFFF : 16'(op.a / op.b);
                er = ez ? op.a     : 16'(op.a % op.b);
                check("model_result", {31'd0, bus.div_zero, bus.quotient, bus.remainder},
                      {31'd0, ez, eq, er});
                if (!ez) begin
                    check("invariant",
                          64'((32'(bus.quotient) * 32'(op.b) + 32'(bus.remainder) == 32'(op.a))
                              && (bus.remainder < op.b)),
                          64'd1);
                end
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        exp_q.push_back('{a: a, b: b});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez,
                          input int hold, input bit poke);
        int lat = 0;
        issue(a, b);
        while (!bus.out_valid && lat < 40) begin
            if (poke && lat == 3) begin
                bus.in_valid = 1'b1;
                bus.dividend = 16'h1111;
                bus.divisor  = 16'h0002;
            end
            if (poke && lat == 4) bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", 64'(lat), (b == 16'd0) ? 64'd0 : 64'd16);
        check("result", {31'd0, bus.div_zero, bus.quotient, bus.remainder}, {31'd0, ez, eq, er});
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 0) begin
                bus.in_valid = 1'b1;
                bus.dividend = 16'h2222;
                bus.divisor  = 16'h0000;
            end
            @(posedge clk);
            #1;
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", {31'd0, bus.div_zero, bus.quotient, bus.remainder},
                  {31'd0, ez, eq, er});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("retire_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state",
              {29'd0, bus.in_ready, bus.out_valid, bus.div_zero, bus.quotient, bus.remainder},
              {29'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});

        do_div(16'd1000,  16'd7,     16'd142,   16'd6,    1'b0, 0, 0);
        do_div(16'hFFFF,  16'h0001,  16'hFFFF,  16'd0,    1'b0, 0, 0);
        do_div(16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0, 0, 0);
        do_div(16'd5,     16'd9,     16'd0,     16'd5,    1'b0, 0, 0);
        do_div(16'd0,     16'd3,     16'd0,     16'd0,    1'b0, 0, 0);
        do_div(16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 0, 0);
        do_div(16'd100,   16'd10,    16'd10,    16'd0,    1'b0, 0, 0);
        do_div(16'd50000, 16'd123,   16'd406,   16'd62,   1'b0, 5, 1);
        do_div(16'd7,     16'd0,     16'hFFFF,  16'd7,    1'b1, 2, 0);

        // Abort 40000/3 partway through the iteration.
        issue(16'd40000, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("mid_calc_reset",
              {29'd0, bus.in_ready, bus.out_valid, bus.div_zero, bus.quotient, bus.remainder},
              {29'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
        do_div(16'd40000, 16'd3, 16'd13333, 16'd1, 1'b0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            if (i % 10 == 0)     b = 16'd0;
            else if (i % 3 == 0) b = 16'($urandom_range(1, 15));
            else                 b = 16'($urandom);
            if (b == 16'd0) do_div(a, b, 16'hFFFF, a, 1'b1, i % 3, 0);
            else            do_div(a, b, a / b, a % b, 1'b0, i % 3, 0);
        end

        check("model_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
